// File: rtl/window_3x3_gen_pkg.sv
// Shared pixel type and default frame geometry for the 3x3 window generator and calc stages.
package window_3x3_gen_pkg;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned IMG_W_DEF = 256;
  localparam int unsigned IMG_H_DEF = 256;

  typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-stream in / 3x3-window out bundle; slave is the window generator, master the source/sink.
interface window_3x3_gen_if;
  import window_3x3_gen_pkg::*;

  pix_t pix_i;
  logic valid_i;
  logic sof_i;
  pix_t d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
  logic done_o;
  logic frame_done_o;

  modport master (
    output pix_i, valid_i, sof_i,
    input  d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o, done_o, frame_done_o
  );

  modport slave (
    input  pix_i, valid_i, sof_i,
    output d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o, done_o, frame_done_o
  );
endinterface

// File: rtl/window_3x3_gen_line_buf.sv
// One image line of storage: synchronous write, combinational read at the write address,
// so a read in the write cycle returns the previous line's pixel.
module window_3x3_gen_line_buf
  import window_3x3_gen_pkg::*;
#(
  parameter  int unsigned DEPTH = IMG_W_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  pix_t          wdata_i,
  output pix_t          rdata_c
);

  pix_t mem_q [DEPTH];

  // Contents are never cleared; stale data is masked by row/col gating upstream.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_c = mem_q[addr_i];

endmodule

// File: rtl/window_3x3_gen.sv
// Raster pixel stream to 3x3 window converter: two chained line buffers, a 3x3 shift
// register and row/col tracking that flags windows lying fully inside the frame.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              rst,
  window_3x3_gen_if.slave   bus
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  pix_t          win_q [9];
  pix_t          win_d [9];
  logic          done_q, done_d;
  logic          frame_done_q, frame_done_d;
  pix_t          l1_rd, l2_rd;

  // A qualified sof forces the current pixel to (0,0) whatever the counters say.
  assign col_eff = (bus.valid_i && bus.sof_i) ? '0 : col_q;
  assign row_eff = (bus.valid_i && bus.sof_i) ? '0 : row_q;

  window_3x3_gen_line_buf #(.DEPTH(IMG_W)) u_l1 (
    .clk     (clk),
    .we_i    (bus.valid_i),
    .addr_i  (col_eff),
    .wdata_i (bus.pix_i),
    .rdata_c (l1_rd)
  );

  window_3x3_gen_line_buf #(.DEPTH(IMG_W)) u_l2 (
    .clk     (clk),
    .we_i    (bus.valid_i),
    .addr_i  (col_eff),
    .wdata_i (l1_rd),
    .rdata_c (l2_rd)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    done_d       = 1'b0;
    frame_done_d = 1'b0;
    if (bus.valid_i) begin
      if (col_eff == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_eff == RW'(IMG_H - 1)) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
      // Each row of the window shifts left; the newest column enters on the right.
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = l2_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = l1_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = bus.pix_i;
      done_d       = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
      frame_done_d = (row_eff == RW'(IMG_H - 1)) && (col_eff == CW'(IMG_W - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '{default: '0};
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      done_q       <= done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.d0_o         = win_q[0];
  assign bus.d1_o         = win_q[1];
  assign bus.d2_o         = win_q[2];
  assign bus.d3_o         = win_q[3];
  assign bus.d4_o         = win_q[4];
  assign bus.d5_o         = win_q[5];
  assign bus.d6_o         = win_q[6];
  assign bus.d7_o         = win_q[7];
  assign bus.d8_o         = win_q[8];
  assign bus.done_o       = done_q;
  assign bus.frame_done_o = frame_done_q;

endmodule
